// File: rtl/alu_shift_addr_datapath_pkg.sv
// Shared encodings for the execute-stage datapath: shifter modes, logic-unit
// selects and the address incrementer step.
package alu_shift_addr_datapath_pkg;

    typedef enum logic [2:0] {
        SH_LSL = 3'd0,
        SH_LSR = 3'd1,
        SH_ASR = 3'd2,
        SH_ROR = 3'd3,
        SH_RRX = 3'd4
    } shift_mode_e;

    typedef enum logic [2:0] {
        LG_AND    = 3'd0,
        LG_ORR    = 3'd1,
        LG_EOR    = 3'd2,
        LG_PASS_B = 3'd3,
        LG_PASS_A = 3'd4
    } logic_op_e;

    localparam logic [31:0] INC_STEP_DEFAULT = 32'd4;

endpackage

// File: rtl/alu_shift_addr_datapath_alu_barrel_shift.sv
// Combinational 32-bit barrel shifter producing shifted data and the shifter
// carry-out (last bit shifted out, or the incoming carry when nothing moves).
module alu_barrel_shift
    import alu_shift_addr_datapath_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [2:0]  mode_i,
    input  logic [4:0]  count_i,
    input  logic        carry_i,
    output logic [31:0] shift_o,
    output logic        carry_o
);

    always_comb begin
        shift_o = data_i;
        carry_o = carry_i;
        case (mode_i)
            SH_LSL: if (count_i != 5'd0) begin
                shift_o = data_i << count_i;
                // bit (32 - count) is the last one pushed out the top
                carry_o = data_i[5'd0 - count_i];
            end
            SH_LSR: if (count_i != 5'd0) begin
                shift_o = data_i >> count_i;
                carry_o = data_i[count_i - 5'd1];
            end
            SH_ASR: if (count_i != 5'd0) begin
                shift_o = $signed(data_i) >>> count_i;
                carry_o = data_i[count_i - 5'd1];
            end
            SH_ROR: if (count_i != 5'd0) begin
                shift_o = (data_i >> count_i) | (data_i << (5'd0 - count_i));
                carry_o = data_i[count_i - 5'd1];
            end
            SH_RRX: begin
                shift_o = {carry_i, data_i[31:1]};
                carry_o = data_i[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_shift_addr_datapath.sv
// Execute-stage slice: barrel shifter on operand B, registered ALU with NZCV
// flags, and an address register with incrementer driving the address bus.
module alu_shift_addr_datapath
    import alu_shift_addr_datapath_pkg::*;
#(
    parameter int              WIDTH    = 32,
    parameter logic [WIDTH-1:0] INC_STEP = INC_STEP_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] bus_a,
    input  logic [WIDTH-1:0] bus_b,
    input  logic [2:0]       shifter_mode,
    input  logic [4:0]       shifter_count,
    input  logic             carry_in,
    input  logic             alu_active,
    input  logic             alu_invert_a,
    input  logic             alu_invert_b,
    input  logic             alu_is_logic,
    input  logic [2:0]       alu_logic_idx,
    input  logic             alu_cin,
    input  logic             ale,
    input  logic             ar_inc,
    input  logic             abe,
    output logic [WIDTH-1:0] shifter_output,
    output logic [WIDTH-1:0] alu_result,
    output logic             alu_n,
    output logic             alu_z,
    output logic             alu_c,
    output logic             alu_v,
    output logic [WIDTH-1:0] incrementerbus,
    output logic [WIDTH-1:0] ar
);

    logic             shift_carry;
    logic [WIDTH-1:0] a_op, b_op, res_d, res_q, ar_q;
    logic [WIDTH:0]   sum;
    logic             n_d, z_d, c_d, v_d;
    logic             n_q, z_q, c_q, v_q;

    alu_barrel_shift u_shift (
        .data_i  (bus_b),
        .mode_i  (shifter_mode),
        .count_i (shifter_count),
        .carry_i (carry_in),
        .shift_o (shifter_output),
        .carry_o (shift_carry)
    );

    assign a_op = alu_invert_a ? ~bus_a : bus_a;
    assign b_op = alu_invert_b ? ~shifter_output : shifter_output;
    assign sum  = {1'b0, a_op} + {1'b0, b_op} + {{WIDTH{1'b0}}, alu_cin};

    always_comb begin
        res_d = sum[WIDTH-1:0];
        c_d   = sum[WIDTH];
        v_d   = (a_op[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a_op[WIDTH-1]);
        if (alu_is_logic) begin
            // logic ops take carry from the shifter and leave V untouched
            c_d = shift_carry;
            v_d = v_q;
            case (alu_logic_idx)
                LG_AND:    res_d = a_op & b_op;
                LG_ORR:    res_d = a_op | b_op;
                LG_EOR:    res_d = a_op ^ b_op;
                LG_PASS_B: res_d = b_op;
                LG_PASS_A: res_d = a_op;
                default:   res_d = '0;
            endcase
        end
        n_d = res_d[WIDTH-1];
        z_d = (res_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q <= '0;
            n_q   <= 1'b0;
            z_q   <= 1'b0;
            c_q   <= 1'b0;
            v_q   <= 1'b0;
        end else if (alu_active) begin
            res_q <= res_d;
            n_q   <= n_d;
            z_q   <= z_d;
            c_q   <= c_d;
            v_q   <= v_d;
        end
    end

    // ale captures the result already on alu_result, not the one being computed
    always_ff @(posedge clk) begin
        if (rst)         ar_q <= '0;
        else if (ale)    ar_q <= res_q;
        else if (ar_inc) ar_q <= incrementerbus;
    end

    assign incrementerbus = ar_q + INC_STEP;
    assign ar             = abe ? ar_q : '0;
    assign alu_result     = res_q;
    assign alu_n          = n_q;
    assign alu_z          = z_q;
    assign alu_c          = c_q;
    assign alu_v          = v_q;

endmodule

// File: tb/tb_alu_shift_addr_datapath.sv
// Directed-vector bench for the execute-stage datapath; expected values are
// hand-computed constants checked with immediate assertions.
module tb_alu_shift_addr_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] bus_a, bus_b;
    logic [2:0]  shifter_mode;
    logic [4:0]  shifter_count;
    logic        carry_in, alu_active, alu_invert_a, alu_invert_b, alu_is_logic;
    logic [2:0]  alu_logic_idx;
    logic        alu_cin, ale, ar_inc, abe;
    logic [31:0] shifter_output, alu_result, incrementerbus, ar;
    logic        alu_n, alu_z, alu_c, alu_v;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_shift_addr_datapath dut (
        .clk            (clk),
        .rst            (rst),
        .bus_a          (bus_a),
        .bus_b          (bus_b),
        .shifter_mode   (shifter_mode),
        .shifter_count  (shifter_count),
        .carry_in       (carry_in),
        .alu_active     (alu_active),
        .alu_invert_a   (alu_invert_a),
        .alu_invert_b   (alu_invert_b),
        .alu_is_logic   (alu_is_logic),
        .alu_logic_idx  (alu_logic_idx),
        .alu_cin        (alu_cin),
        .ale            (ale),
        .ar_inc         (ar_inc),
        .abe            (abe),
        .shifter_output (shifter_output),
        .alu_result     (alu_result),
        .alu_n          (alu_n),
        .alu_z          (alu_z),
        .alu_c          (alu_c),
        .alu_v          (alu_v),
        .incrementerbus (incrementerbus),
        .ar             (ar)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic [3:0] exp_nzcv);
        chk(tag, {28'd0, alu_n, alu_z, alu_c, alu_v}, {28'd0, exp_nzcv});
    endtask

    // advance one edge, then let outputs settle before sampling
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] mode, input logic [4:0] cnt,
                          input logic inv_a, input logic inv_b, input logic is_lg,
                          input logic [2:0] idx, input logic cin);
        bus_a = a; bus_b = b; shifter_mode = mode; shifter_count = cnt;
        alu_invert_a = inv_a; alu_invert_b = inv_b; alu_is_logic = is_lg;
        alu_logic_idx = idx; alu_cin = cin;
        #1;
    endtask

    initial begin
        rst = 1'b1; alu_active = 1'b0; ale = 1'b0; ar_inc = 1'b0; abe = 1'b1;
        carry_in = 1'b0;
        set_op(32'd0, 32'd0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        step(); step();
        rst = 1'b0;
        chk("reset_result", alu_result, 32'h0);
        chk_flags("reset_flags", 4'b0000);
        chk("reset_ar", ar, 32'h0);
        chk("reset_incbus", incrementerbus, 32'h4);

        // ADD 5 + 0x0F
        alu_active = 1'b1;
        set_op(32'd5, 32'h0F, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        chk("lsl0_shift", shifter_output, 32'h0F);
        step();
        chk("add_result", alu_result, 32'h14);
        chk_flags("add_flags", 4'b0000);

        // ADD 5 + (3 LSL 1)
        set_op(32'd5, 32'd3, 3'd0, 5'd1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        chk("lsl1_shift", shifter_output, 32'h6);
        step();
        chk("add_lsl_result", alu_result, 32'hB);

        // AND 5 & (3 LSR 1), carry from shifted-out bit
        set_op(32'd5, 32'd3, 3'd1, 5'd1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
        chk("lsr1_shift", shifter_output, 32'h1);
        step();
        chk("and_result", alu_result, 32'h1);
        chk_flags("and_flags", 4'b0010);

        // SUB 5 - 5
        set_op(32'd5, 32'd5, 3'd0, 5'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1);
        step();
        chk("sub_result", alu_result, 32'h0);
        chk_flags("sub_flags", 4'b0110);

        // signed overflow on ADD
        set_op(32'h7FFFFFFF, 32'd1, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        step();
        chk("ovf_result", alu_result, 32'h80000000);
        chk_flags("ovf_flags", 4'b1001);

        // EOR with pass-through shifter: V must hold at 1
        set_op(32'hF0, 32'hFF, 3'd5, 5'd9, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0);
        chk("pass_shift", shifter_output, 32'hFF);
        step();
        chk("eor_result", alu_result, 32'h0F);
        chk_flags("eor_flags_vhold", 4'b0001);

        // shifter-only checks with the ALU idle: result and flags must hold
        alu_active = 1'b0;
        set_op(32'h0, 32'hFF, 3'd3, 5'd8, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        chk("ror8_shift", shifter_output, 32'hFF000000);
        set_op(32'h0, 32'h80000000, 3'd2, 5'd4, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        chk("asr4_shift", shifter_output, 32'hF8000000);
        carry_in = 1'b1;
        set_op(32'h0, 32'h2, 3'd4, 5'd7, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0);
        chk("rrx_shift", shifter_output, 32'h80000001);
        step();
        chk("idle_hold_result", alu_result, 32'h0F);
        chk_flags("idle_hold_flags", 4'b0001);

        // MOV of RRX result: C = bus_b[0] = 0 even though carry_in = 1
        alu_active = 1'b1;
        step();
        chk("rrx_mov_result", alu_result, 32'h80000001);
        chk_flags("rrx_mov_flags", 4'b1001);

        // MOV of 0x10000000 LSL 4: zero result, carry = bit 28
        carry_in = 1'b0;
        set_op(32'h0, 32'h10000000, 3'd0, 5'd4, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0);
        step();
        chk("lsl4_mov_result", alu_result, 32'h0);
        chk_flags("lsl4_mov_flags", 4'b0111);

        // RSB: 10 - 3
        set_op(32'd3, 32'd10, 3'd0, 5'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
        step();
        chk("rsb_result", alu_result, 32'h7);
        chk_flags("rsb_flags", 4'b0010);

        // BIC: 0xFF & ~0x0F
        set_op(32'hFF, 32'h0F, 3'd0, 5'd0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0);
        step();
        chk("bic_result", alu_result, 32'hF0);

        // address register: load, increment, bus gating, priority, wrap
        set_op(32'd5, 32'h0F, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        step();
        alu_active = 1'b0; ale = 1'b1;
        step();
        chk("ale_ar", ar, 32'h14);
        chk("ale_incbus", incrementerbus, 32'h18);
        ale = 1'b0; ar_inc = 1'b1;
        step();
        chk("inc_ar", ar, 32'h18);
        ar_inc = 1'b0; abe = 1'b0;
        #1;
        chk("abe_off_ar", ar, 32'h0);
        abe = 1'b1;
        ale = 1'b1; ar_inc = 1'b1;
        step();
        chk("ale_over_inc_ar", ar, 32'h14);
        ale = 1'b0; ar_inc = 1'b0; alu_active = 1'b1;
        set_op(32'hFFFFFFF8, 32'h4, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        step();
        alu_active = 1'b0; ale = 1'b1;
        step();
        chk("wrap_pre_ar", ar, 32'hFFFFFFFC);
        chk("wrap_incbus", incrementerbus, 32'h0);
        ale = 1'b0; ar_inc = 1'b1;
        step();
        chk("wrap_ar", ar, 32'h0);

        // ale with concurrent ALU update latches the previous result
        ar_inc = 1'b0;
        set_op(32'hFFFFFFF8, 32'h4, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        alu_active = 1'b1;
        step();
        set_op(32'h10, 32'h10, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        ale = 1'b1;
        step();
        chk("ale_prev_ar", ar, 32'hFFFFFFFC);
        chk("ale_prev_result", alu_result, 32'h20);

        // reset wins over alu_active and ale
        set_op(32'h7FFFFFFF, 32'd1, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0; alu_active = 1'b0; ale = 1'b0;
        chk("rst_mid_result", alu_result, 32'h0);
        chk_flags("rst_mid_flags", 4'b0000);
        chk("rst_mid_ar", ar, 32'h0);
        chk("rst_mid_incbus", incrementerbus, 32'h4);
        step();
        chk("post_rst_hold", alu_result, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
